// File: rtl/alu_addsub_pipe.sv
// Two-stage add/subtract pipeline: S1 registers the effective adder operands, S2 registers
// the result and {N,Z,C,V} flags. Define ALU_ADDSUB_SAT_EN to add signed saturation (in_sat/out_sat).
module alu_addsub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_carry,
`ifdef ALU_ADDSUB_SAT_EN
    input  logic        in_sat,
    output logic        out_sat,
`endif
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 4;

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;
    logic          s1_cin_q, s1_cin_d;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_result_q, s2_result_d;
    logic [FW-1:0] s2_flags_q, s2_flags_d;
`ifdef ALU_ADDSUB_SAT_EN
    logic          s1_sat_q, s1_sat_d;
    logic          s2_sat_q, s2_sat_d;
`endif

    logic          s2_free;
    logic          s1_load;
    logic          s1_move;
    logic          ovf;
    logic [DW-1:0] result;

    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign s1_load  = in_valid && in_ready;
    assign s1_move  = s1_valid_q && s2_free;

    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf = (s1_a_q[DW-1] == s1_b_q[DW-1]) && (add_s[DW-1] != s1_a_q[DW-1]);

    // Result selection (clamped on saturating overflow when enabled).
    always_comb begin
        result = add_s;
`ifdef ALU_ADDSUB_SAT_EN
        if (s1_sat_q && ovf) begin
            result = s1_a_q[DW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

    // Next-state for both stages; S1 refill takes priority over S1 drain.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
`ifdef ALU_ADDSUB_SAT_EN
        s1_sat_d    = s1_sat_q;
        s2_sat_d    = s2_sat_q;
`endif

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            // in_op[0] selects subtract, in_op[1] selects external carry-in.
            s1_b_d     = in_op[0] ? ~in_b : in_b;
            s1_cin_d   = in_op[1] ? in_carry : in_op[0];
`ifdef ALU_ADDSUB_SAT_EN
            s1_sat_d   = in_sat;
`endif
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        if (s1_move) begin
            s2_valid_d  = 1'b1;
            s2_result_d = result;
            s2_flags_d  = {result[DW-1], (result == '0), add_cout, ovf};
`ifdef ALU_ADDSUB_SAT_EN
            s2_sat_d    = s1_sat_q && ovf;
`endif
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
`ifdef ALU_ADDSUB_SAT_EN
            s1_sat_q    <= 1'b0;
            s2_sat_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
`ifdef ALU_ADDSUB_SAT_EN
            s1_sat_q    <= s1_sat_d;
            s2_sat_q    <= s2_sat_d;
`endif
        end
    end

    assign add_a      = s1_a_q;
    assign add_b      = s1_b_q;
    assign add_cin    = s1_cin_q;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;
`ifdef ALU_ADDSUB_SAT_EN
    assign out_sat    = s2_sat_q;
`endif

endmodule

// File: doc/alu_addsub_pipe.md
ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

Interface
REQ-001 Parameters SHALL be none; datapath fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operation valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-007 in_a  input  32  operand A.
REQ-008 in_b  input  32  operand B.
REQ-009 in_carry  input  1  carry-in used by ADC/SBC only.
REQ-010 add_a  output  32  to 32-bit prefix adder operand a.
REQ-011 add_b  output  32  to adder operand b.
REQ-012 add_cin  output  1  to adder carry-in.
REQ-013 add_s  input  32  adder sum (combinational return).
REQ-014 add_cout  input  1  adder carry-out.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_result  output  32  registered result.
REQ-018 out_flags  output  4  {N,Z,C,V}.

Function
REQ-019 Two register stages SHALL exist: S1 (effective operands, op, valid) and S2 (result, flags, valid).
REQ-020 Acceptance SHALL occur on a rising edge with in_valid & in_ready; S1 loads then.
REQ-021 S1 effective operands: ADD a,b,cin=0; SUB a,~b,cin=1; ADC a,b,cin=in_carry; SBC a,~b,cin=in_carry.
REQ-022 add_a/add_b/add_cin SHALL be driven directly from S1 registers, no combinational path from in_*.
REQ-023 s2_free = !S2.valid | out_ready; S1 SHALL transfer into S2 on an edge where S1.valid & s2_free.
REQ-024 in_ready SHALL equal !S1.valid | s2_free (combinational, no dependency on in_valid).
REQ-025 Latency: result SHALL appear with out_valid=1 exactly 2 edges after acceptance when no backpressure; throughput one op/cycle.
REQ-026 out_valid high with out_ready low SHALL hold out_result/out_flags stable; no op dropped or duplicated.
REQ-027 S2 invalidates on edge with out_ready & !S1.valid; simultaneous drain and refill SHALL load new S1 data.
REQ-028 Flags: N=result[31]; Z=(result==0); C=add_cout (SUB/SBC: 1 = no borrow); V=(add_a[31]==add_b[31]) & (add_s[31]!=add_a[31]).
REQ-029 Arithmetic SHALL be modulo 2^32; carry beyond bit 31 reported only in C.

Reset
REQ-030 rst_n low SHALL immediately clear S1.valid, S2.valid, all S1/S2 data, add_a/add_b/add_cin, out_result, out_flags to 0.
REQ-031 Reset mid-operation SHALL discard in-flight ops; in_ready=1 during and after reset.
REQ-032 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro ALU_ADDSUB_SAT_EN defined: ports in_sat (input 1, latched with op) and out_sat (output 1) SHALL exist; when latched sat=1 and V=1, out_result SHALL clamp to 32'h7FFF_FFFF if add_a[31]=0 else 32'h8000_0000, out_sat=1, N/Z computed on clamped value, V still 1.
REQ-034 Macro undefined: in_sat/out_sat SHALL not exist; results always wrap per REQ-029.
REQ-035 out_sat SHALL reset to 0 and follow S2 timing identically to out_result.

Verification
REQ-036 ADD 0xFFFF_FFFF + 0x1, out_ready=1 -> 2 edges later out_result=0, flags N0 Z1 C1 V0.
REQ-037 SUB 5 - 7 -> out_result=0xFFFF_FFFE, flags N1 Z0 C0 V0; add_b=0xFFFF_FFF8, add_cin=1 during S1.
REQ-038 ADD 0x7FFF_FFFF + 1 -> 0x8000_0000, V1; with ALU_ADDSUB_SAT_EN and in_sat=1 -> 0x7FFF_FFFF, out_sat=1.
REQ-039 Back-to-back 4 ops, out_ready low 3 cycles after first result -> in_ready drops after S1 fills, all 4 results delivered in order, none lost.
REQ-040 rst_n pulsed low while S1 and S2 valid -> out_valid=0, outputs 0 asynchronously; next accepted ADC 1+1,carry=1 -> 3.
